fcvt_float_seq: RTL and testbench
=================================

Name: fcvt_float_seq

Overview:
Multi-cycle integer-to-floating-point conversion stage (FCVT.D.L/LU at BUS_WIDTH=64, FCVT.S.W/WU at BUS_WIDTH=32) in the FPU.
- Accepts an integer operand over a valid/ready handshake.
- Normalizes it iteratively with a leading-zero shift FSM.
- Returns an IEEE-754 value rounded toward zero, matching the truncating float-to-int path it feeds through the FP register file.
- Flags inexact results.

Parameters:
BUS_WIDTH, 64, operand/result width; 64 selects double (11-bit exponent, 52-bit mantissa, bias 1023), 32 selects single (8, 23, 127).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  high only in IDLE
in1  input  BUS_WIDTH  integer operand
is_signed  input  1  1: in1 is two's complement; 0: unsigned
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
out  output  BUS_WIDTH  IEEE-754 result {S,E,M}
inexact  output  1  1 if any nonzero bits were truncated; valid with out_valid

Behaviour:
- Reset is asynchronous: state=IDLE, out=0, out_valid=0, inexact=0, internal regs=0. in_ready is combinational (state==IDLE), so it reads 1 during reset.
- Reset asserted mid-operation: conversion dropped, nothing emitted.
- States: IDLE, NORM, PACK, DONE.
- IDLE:
  - Accept on in_valid & in_ready.
  - If in1==0: out<=0, inexact<=0, go to DONE. Result is visible after the accept edge.
  - Otherwise: sign<=is_signed & in1[MSB]; mag<=sign ? (~in1+1) : in1, taken as unsigned BUS_WIDTH bits (signed minimum gives mag=2^(BUS_WIDTH-1)); exp<=BUS_WIDTH-1 (7-bit counter); go to NORM.
- NORM, one action per cycle:
  - If mag[MSB]==1: go to PACK.
  - Else if mag[MSB:MSB-3]==0: mag<<=4, exp-=4.
  - Else: mag<<=1, exp-=1.
  - Cycle count n = floor(lz/4) + (lz mod 4) + 1, where lz = leading zeros of mag. Maximum is 19 at 64-bit and 11 at 32-bit.
- PACK:
  - out<={sign, exp+BIAS (EXPONENT_SIZE bits), mag[MSB-1 : MSB-MANTISSA_SIZE]}.
  - inexact<=|mag[MSB-MANTISSA_SIZE-1:0]; always 0 at 32-bit when exp<=23.
  - Go to DONE.
  - Overflow is impossible: exponent is at most BUS_WIDTH-1.
- DONE:
  - out_valid=1; out and inexact held stable.
  - On out_ready go to IDLE. out_valid drops the next cycle.
  - out keeps its last value, so out is stable from the handshake onward.
  - in_valid is ignored in DONE; no new operand is accepted in the same cycle as result acceptance.
- Latency: accept edge T, then out_valid high after edge T+n+1 (nonzero operand) or after edge T (zero). Throughput is one operation per latency+2 cycles.
- Rounding: round toward zero only; no rounding-mode input.
- Output is never NaN or infinity. -0 is never produced (in1==0 yields +0).

Test Plan:
1. BUS_WIDTH=64, is_signed=0, in1=1 -> n=19, out_valid after 20 edges past accept, out=0x3FF0000000000000, inexact=0.
2. BUS_WIDTH=64, is_signed=1: in1=0xFFFFFFFFFFFFFFFF -> out=0xBFF0000000000000; in1=0x8000000000000000 -> n=1, out=0xC3E0000000000000, inexact=0.
3. BUS_WIDTH=64, is_signed=0, in1=0xFFFFFFFFFFFFFFFF -> out=0x43EFFFFFFFFFFFFF, inexact=1. Same in1 with is_signed=1 -> 0xBFF0000000000000.
4. BUS_WIDTH=32, is_signed=1, in1=3 -> 0x40400000. in1=0 -> 0x00000000, out_valid the cycle after accept. in1=0x01000001 -> 0x4B800000, inexact=1.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with a new operand -> out, inexact, out_valid unchanged; in_ready=0; second operand not accepted until after the handshake.
6. Reset: assert rst_n=0 asynchronously during NORM -> out_valid=0, out=0, in_ready=1 immediately. A subsequent in1=5 unsigned (64-bit) -> 0x4014000000000000.

Source files
------------

// File: rtl/fcvt_float_seq.sv
// Integer-to-IEEE-754 converter (signed/unsigned), truncating, with an inexact flag.
// Latency: n+1 cycles from accept to out_valid (n = NORM iterations), 0 for a zero operand.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module fcvt_float_seq #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 inexact
);

  // Format geometry: 64 bits selects double, anything else single.
  localparam int EXP_SIZE  = (BUS_WIDTH == 64) ? 11 : 8;
  localparam int MANT_SIZE = (BUS_WIDTH == 64) ? 52 : 23;
  // Bits below the mantissa once the leading one sits in the MSB.
  localparam int LOW_SIZE  = BUS_WIDTH - 1 - MANT_SIZE;
  localparam logic [EXP_SIZE-1:0] BIAS = EXP_SIZE'((1 << (EXP_SIZE - 1)) - 1);
  localparam logic [BUS_WIDTH-1:0] ONE = BUS_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   sign_q;
  logic [BUS_WIDTH-1:0]   mag_q;
  logic [6:0]             exp_q;
  logic [BUS_WIDTH-1:0]   out_q;
  logic                   inexact_q;
  logic                   neg;
  logic [EXP_SIZE-1:0]    exp_biased;

  assign neg        = is_signed & in1[BUS_WIDTH-1];
  // exp_q never exceeds BUS_WIDTH-1, so the biased exponent cannot overflow.
  assign exp_biased = {{(EXP_SIZE-7){1'b0}}, exp_q} + BIAS;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_q;
  assign inexact   = inexact_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; zero skips normalisation, DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = (in1 == '0) ? DONE : NORM;
        end
      end
      NORM: begin
        if (mag_q[BUS_WIDTH-1]) begin
          state_nxt = PACK;
        end
      end
      PACK:    state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture magnitude, shift out leading zeros, then pack fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      out_q     <= '0;
      inexact_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in1 == '0) begin
              // Zero maps straight to +0, never -0.
              out_q     <= '0;
              inexact_q <= 1'b0;
            end else begin
              sign_q <= neg;
              // Signed minimum negates to itself, read as unsigned 2^(W-1).
              mag_q  <= neg ? (~in1 + ONE) : in1;
              exp_q  <= 7'(BUS_WIDTH - 1);
            end
          end
        end
        NORM: begin
          if (!mag_q[BUS_WIDTH-1]) begin
            // Nibble steps first, single steps to finish the last 0..3 zeros.
            if (mag_q[BUS_WIDTH-1 -: 4] == 4'd0) begin
              mag_q <= mag_q << 4;
              exp_q <= exp_q - 7'd4;
            end else begin
              mag_q <= mag_q << 1;
              exp_q <= exp_q - 7'd1;
            end
          end
        end
        PACK: begin
          // Hidden one (MSB) dropped; bits under the mantissa are truncated.
          out_q     <= {sign_q, exp_biased, mag_q[BUS_WIDTH-2 -: MANT_SIZE]};
          inexact_q <= |mag_q[LOW_SIZE-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_float_seq.sv
// Directed bench for fcvt_float_seq at 64-bit (double) and 32-bit (single).
// Each scenario task drives its vectors and compares against hand-computed values.
// Handshake, backpressure and asynchronous reset are exercised as well.
module tb_fcvt_float_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v64 = 1'b0, r64, s64 = 1'b0, ov64, or64 = 1'b0, x64;
  logic [63:0] a64 = '0, o64;
  logic        v32 = 1'b0, r32, s32 = 1'b0, ov32, or32 = 1'b0, x32;
  logic [31:0] a32 = '0, o32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fcvt_float_seq #(.BUS_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in1(a64),
    .is_signed(s64), .out_valid(ov64), .out_ready(or64), .out(o64), .inexact(x64)
  );

  fcvt_float_seq #(.BUS_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in1(a32),
    .is_signed(s32), .out_valid(ov32), .out_ready(or32), .out(o32), .inexact(x32)
  );

  // Drive one 64-bit operand, wait (bounded) for the result, capture it and accept it.
  task automatic op64(input logic [63:0] a, input logic s, output logic [63:0] o,
                      output logic x, output int cyc, output logic vld_after);
    v64 = 1'b1; a64 = a; s64 = s;
    @(posedge clk); #1;
    v64 = 1'b0; cyc = 0;
    while (ov64 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    o = o64; x = x64;
    or64 = 1'b1;
    @(posedge clk); #1;
    or64 = 1'b0;
    vld_after = ov64;
  endtask

  task automatic op32(input logic [31:0] a, input logic s, output logic [31:0] o,
                      output logic x, output int cyc);
    v32 = 1'b1; a32 = a; s32 = s;
    @(posedge clk); #1;
    v32 = 1'b0; cyc = 0;
    while (ov32 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    o = o32; x = x32;
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (r64 !== 1'b1) begin bad++; $display("FAIL reset_in_ready64 got=%b want=1", r64); end
    total++; if (ov64 !== 1'b0) begin bad++; $display("FAIL reset_out_valid64 got=%b want=0", ov64); end
    total++; if (o64 !== 64'h0) begin bad++; $display("FAIL reset_out64 got=%h want=0", o64); end
    total++; if (x64 !== 1'b0) begin bad++; $display("FAIL reset_inexact64 got=%b want=0", x64); end
    total++; if (r32 !== 1'b1) begin bad++; $display("FAIL reset_in_ready32 got=%b want=1", r32); end
    total++; if (ov32 !== 1'b0) begin bad++; $display("FAIL reset_out_valid32 got=%b want=0", ov32); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_one64();
    logic [63:0] o; logic x, va; int c;
    op64(64'd1, 1'b0, o, x, c, va);
    total++; if (o !== 64'h3FF0000000000000) begin bad++; $display("FAIL one64_out got=%h want=3ff0000000000000", o); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL one64_inexact got=%b want=0", x); end
    total++; if (c !== 20) begin bad++; $display("FAIL one64_latency got=%0d want=20", c); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL one64_valid_drop got=%b want=0", va); end
  endtask

  task automatic test_signed64();
    logic [63:0] o; logic x, va; int c;
    op64(64'hFFFFFFFFFFFFFFFF, 1'b1, o, x, c, va);
    total++; if (o !== 64'hBFF0000000000000) begin bad++; $display("FAIL neg1_64_out got=%h want=bff0000000000000", o); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL neg1_64_inexact got=%b want=0", x); end
    op64(64'h8000000000000000, 1'b1, o, x, c, va);
    total++; if (o !== 64'hC3E0000000000000) begin bad++; $display("FAIL min64_out got=%h want=c3e0000000000000", o); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL min64_inexact got=%b want=0", x); end
    total++; if (c !== 2) begin bad++; $display("FAIL min64_latency got=%0d want=2", c); end
  endtask

  task automatic test_unsigned_max64();
    logic [63:0] o; logic x, va; int c;
    op64(64'hFFFFFFFFFFFFFFFF, 1'b0, o, x, c, va);
    total++; if (o !== 64'h43EFFFFFFFFFFFFF) begin bad++; $display("FAIL umax64_out got=%h want=43efffffffffffff", o); end
    total++; if (x !== 1'b1) begin bad++; $display("FAIL umax64_inexact got=%b want=1", x); end
    total++; if (c !== 2) begin bad++; $display("FAIL umax64_latency got=%0d want=2", c); end
  endtask

  task automatic test_single32();
    logic [31:0] o; logic x; int c;
    op32(32'd3, 1'b1, o, x, c);
    total++; if (o !== 32'h40400000) begin bad++; $display("FAIL three32_out got=%h want=40400000", o); end
    total++; if (c !== 11) begin bad++; $display("FAIL three32_latency got=%0d want=11", c); end
    op32(32'd0, 1'b1, o, x, c);
    total++; if (o !== 32'h0) begin bad++; $display("FAIL zero32_out got=%h want=00000000", o); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL zero32_inexact got=%b want=0", x); end
    total++; if (c !== 0) begin bad++; $display("FAIL zero32_latency got=%0d want=0", c); end
    op32(32'h01000001, 1'b1, o, x, c);
    total++; if (o !== 32'h4B800000) begin bad++; $display("FAIL big32_out got=%h want=4b800000", o); end
    total++; if (x !== 1'b1) begin bad++; $display("FAIL big32_inexact got=%b want=1", x); end
    op32(32'd1, 1'b0, o, x, c);
    total++; if (o !== 32'h3F800000) begin bad++; $display("FAIL one32_out got=%h want=3f800000", o); end
    total++; if (c !== 12) begin bad++; $display("FAIL one32_latency got=%0d want=12", c); end
    op32(32'hFFFFFFF9, 1'b1, o, x, c);
    total++; if (o !== 32'hC0E00000) begin bad++; $display("FAIL neg7_32_out got=%h want=c0e00000", o); end
  endtask

  task automatic test_backpressure();
    int c;
    v64 = 1'b1; a64 = 64'd3; s64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0; c = 0;
    while (ov64 !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    for (int i = 0; i < 5; i++) begin
      v64 = 1'b1; a64 = 64'd7; s64 = 1'b0;
      total++; if (ov64 !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, ov64); end
      total++; if (o64 !== 64'h4008000000000000) begin bad++; $display("FAIL bp_hold_out[%0d] got=%h want=4008000000000000", i, o64); end
      total++; if (x64 !== 1'b0) begin bad++; $display("FAIL bp_hold_inexact[%0d] got=%b want=0", i, x64); end
      total++; if (r64 !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, r64); end
      @(posedge clk); #1;
    end
    or64 = 1'b1;
    @(posedge clk); #1;
    or64 = 1'b0;
    total++; if (ov64 !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b want=0", ov64); end
    total++; if (r64 !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", r64); end
    total++; if (o64 !== 64'h4008000000000000) begin bad++; $display("FAIL bp_out_stable got=%h want=4008000000000000", o64); end
    @(posedge clk); #1;
    v64 = 1'b0; c = 0;
    while (ov64 !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    total++; if (o64 !== 64'h401C000000000000) begin bad++; $display("FAIL bp_second_out got=%h want=401c000000000000", o64); end
    total++; if (c !== 18) begin bad++; $display("FAIL bp_second_latency got=%0d want=18", c); end
    or64 = 1'b1;
    @(posedge clk); #1;
    or64 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [63:0] o; logic x, va; int c; int seen;
    v64 = 1'b1; a64 = 64'd1; s64 = 1'b0;
    @(posedge clk); #1;
    v64 = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    total++; if (ov64 !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", ov64); end
    total++; if (o64 !== 64'h0) begin bad++; $display("FAIL arst_out got=%h want=0", o64); end
    total++; if (r64 !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", r64); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (ov64 === 1'b1) seen++;
      @(posedge clk); #1;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL arst_dropped got=%0d valid cycles want=0", seen); end
    op64(64'd5, 1'b0, o, x, c, va);
    total++; if (o !== 64'h4014000000000000) begin bad++; $display("FAIL after_rst_out got=%h want=4014000000000000", o); end
    total++; if (x !== 1'b0) begin bad++; $display("FAIL after_rst_inexact got=%b want=0", x); end
  endtask

  initial begin
    test_reset();
    test_one64();
    test_signed64();
    test_unsigned_max64();
    test_single32();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
